pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register; successor to the fixed per-stage
//  IF/ID, ID/EX and EX/MEM registers. Carries one opaque data vector and one

---
 rtl/pipe_stage_skid_if.sv | 27 ++
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream offer, downstream take,
// flush and occupancy. master = the environment, slave = the stage.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 11
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage register with valid/ready handshake,
// registered in_ready, synchronous flush and zero-control bubbles.
module pipe_stage_skid #(
    parameter int DATA_W     = 96,
    parameter int CTRL_W     = 11,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_skid_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_in_ready  = (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_ctrl  = r_main_ctrl;
    assign bus.occupancy = r_state;

    // r_main_ctrl is zeroed on every transition into ST_EMPTY, so out_ctrl
    // is already a clean bubble without any output gating.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the payload registers are reset too, so out_data and the skid
        // entry come up as zero instead of X after reset.
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge state of main and skid.
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= bus.in_data;
                        r_main_ctrl <= bus.in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= bus.in_data;
                        r_main_ctrl <= bus.in_ctrl;
                    end else if (w_in_fire) begin
                        r_state     <= ST_TWO;
                        r_skid_data <= bus.in_data;
                        r_skid_ctrl <= bus.in_ctrl;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_main_ctrl <= '0;
                        if (CLEAR_DATA) begin
                            r_main_data <= '0;
                        end
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_skid_ctrl <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a FIFO-of-two queue model checked every cycle,
// plus directed literal checks, on one CLEAR_DATA=1 and one CLEAR_DATA=0 copy.
module tb_pipe_stage_skid;
    localparam int DW = 96;
    localparam int CW = 11;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus2 ();

    assign bus2.flush     = bus1.flush;
    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_data   = bus1.in_data;
    assign bus2.in_ctrl   = bus1.in_ctrl;
    assign bus2.out_ready = bus1.out_ready;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut_clr (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut_keep (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus2)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
        return {21'h1ABCD, c, ~{21'h0, c}, 32'hC0DE_0000 | {21'h0, c}};
    endfunction

    // Model: the stage is a FIFO of capacity two; zero_* flag when out_data must read 0.
    ent_t q[$];
    bit   zero_clr;
    bit   zero_keep;
    bit   m_rdy;
    bit   m_vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            zero_clr  = 1'b1;
            zero_keep = 1'b1;
        end else begin
            m_rdy = (q.size() < 2);
            m_vld = (q.size() > 0);
            if (bus1.flush) begin
                q.delete();
                zero_clr = 1'b1;
            end else begin
                if (m_vld && bus1.out_ready) void'(q.pop_front());
                if (bus1.in_valid && m_rdy) begin
                    q.push_back('{d: bus1.in_data, c: bus1.in_ctrl});
                    zero_clr  = 1'b0;
                    zero_keep = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("clr_occ",    128'(bus1.occupancy), 128'(q.size()));
        check("clr_valid",  128'(bus1.out_valid), 128'(q.size() > 0));
        check("clr_ready",  128'(bus1.in_ready),  128'(q.size() < 2));
        check("keep_occ",   128'(bus2.occupancy), 128'(q.size()));
        check("keep_valid", 128'(bus2.out_valid), 128'(q.size() > 0));
        check("keep_ready", 128'(bus2.in_ready),  128'(q.size() < 2));
        if (q.size() > 0) begin
            check("clr_ctrl",  128'(bus1.out_ctrl), 128'(q[0].c));
            check("clr_data",  128'(bus1.out_data), 128'(q[0].d));
            check("keep_ctrl", 128'(bus2.out_ctrl), 128'(q[0].c));
            check("keep_data", 128'(bus2.out_data), 128'(q[0].d));
        end else begin
            check("clr_bubble",  128'(bus1.out_ctrl), 128'(0));
            check("keep_bubble", 128'(bus2.out_ctrl), 128'(0));
            if (zero_clr)  check("clr_zdata",  128'(bus1.out_data), 128'(0));
            if (zero_keep) check("keep_zdata", 128'(bus2.out_data), 128'(0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] c, input logic ordy, input logic fl);
        bus1.in_valid  = iv;
        bus1.in_ctrl   = c;
        bus1.in_data   = mk_data(c);
        bus1.out_ready = ordy;
        bus1.flush     = fl;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [CW-1:0] c, input logic [1:0] occ, input logic rdy);
        check({name, "_valid"}, 128'(bus1.out_valid), 128'(v));
        check({name, "_ctrl"},  128'(bus1.out_ctrl),  128'(c));
        check({name, "_occ"},   128'(bus1.occupancy), 128'(occ));
        check({name, "_ready"}, 128'(bus1.in_ready),  128'(rdy));
    endtask

    logic [31:0] pat_iv;
    logic [31:0] pat_or;
    logic [31:0] pat_fl;

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) cyc();
        expect_out("rst", 1'b0, 11'h000, 2'd0, 1'b1);
        check("rst_data", 128'(bus1.out_data), 128'(0));
        rst_n = 1'b1;

        // Streaming at full rate with one-cycle latency.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, CW'(k), 1'b1, 1'b0);
            cyc();
            expect_out("stream", 1'b1, CW'(k), 2'd1, 1'b1);
            check("stream_data", 128'(bus1.out_data), 128'(mk_data(CW'(k))));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        expect_out("drain", 1'b0, 11'h000, 2'd0, 1'b1);

        // Fill the skid entry under stall, then release.
        drive(1'b1, 11'h00A, 1'b0, 1'b0);
        cyc();
        expect_out("pushA", 1'b1, 11'h00A, 2'd1, 1'b1);
        drive(1'b1, 11'h00B, 1'b0, 1'b0);
        cyc();
        expect_out("pushB", 1'b1, 11'h00A, 2'd2, 1'b0);
        drive(1'b1, 11'h0EE, 1'b0, 1'b0);
        cyc();
        expect_out("stallB", 1'b1, 11'h00A, 2'd2, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        expect_out("popA", 1'b1, 11'h00B, 2'd1, 1'b1);
        cyc();
        expect_out("popB", 1'b0, 11'h000, 2'd0, 1'b1);

        // Flush while full with a concurrent offer of 0x7FF.
        drive(1'b1, 11'h00C, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 11'h00D, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 11'h7FF, 1'b0, 1'b1);
        cyc();
        expect_out("flush", 1'b0, 11'h000, 2'd0, 1'b1);
        check("flush_data", 128'(bus1.out_data), 128'(0));
        drive(1'b0, '0, 1'b0, 1'b0);
        cyc();
        expect_out("post_flush", 1'b0, 11'h000, 2'd0, 1'b1);

        // Simultaneous accept and consume with one entry held.
        drive(1'b1, 11'h00E, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 11'h00F, 1'b1, 1'b0);
        cyc();
        expect_out("swap", 1'b1, 11'h00F, 2'd1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        expect_out("swap_drain", 1'b0, 11'h000, 2'd0, 1'b1);

        // Flush with CLEAR_DATA=0: control cleared, data left alone.
        bus1.in_valid  = 1'b1;
        bus1.in_ctrl   = 11'h005;
        bus1.in_data   = 96'hABC;
        bus1.out_ready = 1'b0;
        bus1.flush     = 1'b0;
        cyc();
        check("keep_held_data", 128'(bus2.out_data), 128'(96'hABC));
        drive(1'b0, '0, 1'b0, 1'b1);
        cyc();
        check("keep_flush_ctrl",  128'(bus2.out_ctrl),  128'(0));
        check("keep_flush_valid", 128'(bus2.out_valid), 128'(0));

        // Asynchronous reset while two entries are held.
        drive(1'b1, 11'h011, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 11'h012, 1'b0, 1'b0);
        cyc();
        expect_out("pre_rst", 1'b1, 11'h011, 2'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 11'h000, 2'd0, 1'b1);
        check("async_rst_keep_occ",  128'(bus2.occupancy), 128'(0));
        check("async_rst_keep_ctrl", 128'(bus2.out_ctrl),  128'(0));
        check("async_rst_keep_data", 128'(bus2.out_data),  128'(0));
        cyc();
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 11'h013, 1'b0, 1'b0);
        cyc();
        expect_out("first_accept", 1'b1, 11'h013, 2'd1, 1'b1);

        // Mixed traffic with stalls and flushes, checked by the model only.
        pat_iv = 32'b1101_1111_0110_1011_1110_0111_1011_1101;
        pat_or = 32'b0110_0011_1101_0010_1011_1100_0111_0101;
        pat_fl = 32'b0000_0100_0000_0000_1000_0000_0001_0000;
        for (int i = 0; i < 32; i++) begin
            drive(pat_iv[i], CW'(i + 32), pat_or[i], pat_fl[i]);
            cyc();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
